// File: rtl/rl_ram_arb_pkg.sv
// Shared helpers for the single-port RAM arbiter: derived widths and
// one-hot to binary index conversion.
package rl_ram_arb_pkg;

  // Byte-enable width for a data word of dbits bits.
  function automatic int be_bits(input int dbits);
    return (dbits + 7) / 8;
  endfunction

  // Index width for n requesters, never below one bit.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Binary index of a one-hot vector (up to 16 requesters); all-zero maps to 0.
  function automatic logic [3:0] onehot_to_idx(input logic [15:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (oh[i]) idx = idx | 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rl_rr_arbiter.sv
// Purely combinational round-robin search: starting one past ptr_i and
// wrapping modulo NPORTS, grant the first requesting port.
module rl_rr_arbiter
  import rl_ram_arb_pkg::*;
#(
  parameter int  NPORTS = 4,
  localparam int IW     = idx_bits(NPORTS)
) (
  input  logic [NPORTS-1:0] req_i,
  input  logic [IW-1:0]     ptr_i,
  output logic [NPORTS-1:0] gnt_o,
  output logic [IW-1:0]     idx_o,
  output logic              any_o
);

  logic [IW-1:0] w_cand;

  // Walk the ports in priority order from ptr_i+1; the first request wins.
  always_comb begin
    gnt_o  = '0;
    w_cand = '0;
    for (int k = 1; k <= NPORTS; k++) begin
      w_cand = IW'((int'(ptr_i) + k) % NPORTS);
      if (req_i[w_cand] && (gnt_o == '0)) gnt_o[w_cand] = 1'b1;
    end
    any_o = |gnt_o;
    idx_o = IW'(onehot_to_idx(16'(gnt_o)));
  end

endmodule

// File: rtl/rl_ram_1rw_arbiter.sv
// Shares one 1RW RAM among NPORTS requesters with round-robin priority and a
// bounded lock for back-to-back bursts.
// Handshake: a requester raises req_i[n] with its payload and holds both
// stable until it sees gnt_o[n]; the access completes on the rising edge at
// which gnt_o[n] is high. For reads, rvalid_o[n] is high for exactly one
// cycle after that edge, and dout_o is meaningful only while it is high.
module rl_ram_1rw_arbiter
  import rl_ram_arb_pkg::*;
#(
  parameter int  NPORTS   = 4,
  parameter int  ABITS    = 10,
  parameter int  DBITS    = 32,
  parameter int  MAX_LOCK = 8,
  localparam int BEBITS   = be_bits(DBITS)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NPORTS-1:0]        req_i,
  input  logic [NPORTS-1:0]        lock_i,
  input  logic [NPORTS*ABITS-1:0]  addr_i,
  input  logic [NPORTS-1:0]        we_i,
  input  logic [NPORTS*BEBITS-1:0] be_i,
  input  logic [NPORTS*DBITS-1:0]  din_i,
  output logic [NPORTS-1:0]        gnt_o,
  output logic [NPORTS-1:0]        rvalid_o,
  output logic [DBITS-1:0]         dout_o,
  output logic [ABITS-1:0]         ram_addr_o,
  output logic                     ram_we_o,
  output logic [BEBITS-1:0]        ram_be_o,
  output logic [DBITS-1:0]         ram_din_o,
  input  logic [DBITS-1:0]         ram_dout_i
);

  localparam int         IW        = idx_bits(NPORTS);
  localparam logic [7:0] MAX_LOCK_C = 8'(MAX_LOCK);

  logic [IW-1:0]     r_last;
  logic [IW-1:0]     r_owner;
  logic              r_locked;
  logic [7:0]        r_lock_cnt;
  logic [NPORTS-1:0] r_rvalid;
  logic [ABITS-1:0]  r_addr_hold;
  logic [DBITS-1:0]  r_din_hold;

  logic [NPORTS-1:0] w_rr_gnt;
  logic [IW-1:0]     w_rr_idx;
  logic              w_rr_any;
  logic              w_lock_active;
  logic [NPORTS-1:0] w_gnt;
  logic [IW-1:0]     w_idx;
  logic              w_any;
  logic [ABITS-1:0]  w_sel_addr;
  logic [DBITS-1:0]  w_sel_din;
  logic [BEBITS-1:0] w_sel_be;
  logic              w_sel_we;
  logic              w_sel_lock;
  logic              w_locked_next;
  logic [IW-1:0]     w_owner_next;
  logic [7:0]        w_cnt_next;

  rl_rr_arbiter #(.NPORTS(NPORTS)) u_rr (
    .req_i (req_i),
    .ptr_i (r_last),
    .gnt_o (w_rr_gnt),
    .idx_o (w_rr_idx),
    .any_o (w_rr_any)
  );

  // The lock only holds while its owner keeps requesting.
  assign w_lock_active = r_locked & req_i[r_owner];

  // Final grant: nothing in reset, the lock owner if active, else round-robin.
  always_comb begin
    w_gnt = '0;
    w_idx = '0;
    w_any = 1'b0;
    if (!rst_i) begin
      if (w_lock_active) begin
        w_gnt[r_owner] = 1'b1;
        w_idx          = r_owner;
        w_any          = 1'b1;
      end else begin
        w_gnt = w_rr_gnt;
        w_idx = w_rr_idx;
        w_any = w_rr_any;
      end
    end
  end

  // One-hot AND-OR mux of the granted port's payload; zero when idle.
  always_comb begin
    w_sel_addr = '0;
    w_sel_din  = '0;
    w_sel_be   = '0;
    w_sel_we   = 1'b0;
    w_sel_lock = 1'b0;
    for (int n = 0; n < NPORTS; n++) begin
      if (w_gnt[n]) begin
        w_sel_addr = addr_i[n*ABITS +: ABITS];
        w_sel_din  = din_i[n*DBITS +: DBITS];
        w_sel_be   = be_i[n*BEBITS +: BEBITS];
        w_sel_we   = we_i[n];
        w_sel_lock = lock_i[n];
      end
    end
  end

  // Lock bookkeeping: start or extend on a locked grant, drop on anything else,
  // and release right after the grant that brings the count to MAX_LOCK.
  always_comb begin
    w_locked_next = 1'b0;
    w_owner_next  = r_owner;
    w_cnt_next    = '0;
    if (w_any && w_sel_lock) begin
      w_cnt_next    = w_lock_active ? (r_lock_cnt + 8'd1) : 8'd1;
      w_owner_next  = w_idx;
      w_locked_next = 1'b1;
      if (w_cnt_next >= MAX_LOCK_C) begin
        w_locked_next = 1'b0;
        w_cnt_next    = '0;
      end
    end
  end

  // Lock state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_locked   <= 1'b0;
      r_owner    <= '0;
      r_lock_cnt <= '0;
    end else begin
      r_locked   <= w_locked_next;
      r_owner    <= w_owner_next;
      r_lock_cnt <= w_cnt_next;
    end
  end

  // Pointer and held RAM address/data follow every grant so idle cycles don't toggle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_last      <= IW'(NPORTS - 1);
      r_addr_hold <= '0;
      r_din_hold  <= '0;
    end else if (w_any) begin
      r_last      <= w_idx;
      r_addr_hold <= w_sel_addr;
      r_din_hold  <= w_sel_din;
    end
  end

  // Read-return strobe: one cycle after a granted read, cleared by reset at once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_rvalid <= '0;
    else       r_rvalid <= w_gnt & ~we_i;
  end

  assign gnt_o      = w_gnt;
  assign rvalid_o   = r_rvalid;
  assign dout_o     = ram_dout_i;
  assign ram_addr_o = w_any ? w_sel_addr : r_addr_hold;
  assign ram_din_o  = w_any ? w_sel_din : r_din_hold;
  assign ram_we_o   = w_any & w_sel_we;
  assign ram_be_o   = w_any ? w_sel_be : '0;

endmodule

// File: tb/tb_rl_ram_1rw_arbiter.sv
// Bench for rl_ram_1rw_arbiter: behavioural RAM on the ram_* side, an
// arbitration/memory reference model, and a negedge monitor against queues.
module tb_rl_ram_1rw_arbiter;

  localparam int NP = 4;
  localparam int AB = 10;
  localparam int DB = 32;
  localparam int BB = 4;
  localparam int ML = 8;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst;
  logic [NP-1:0]    req, lock, we;
  logic [NP*AB-1:0] addr;
  logic [NP*BB-1:0] be;
  logic [NP*DB-1:0] din;
  logic [NP-1:0]    gnt, rvalid;
  logic [DB-1:0]    dout, ram_din, ram_dout;
  logic [AB-1:0]    ram_addr;
  logic             ram_we;
  logic [BB-1:0]    ram_be;

  always #5 clk = ~clk;

  rl_ram_1rw_arbiter #(.NPORTS(NP), .ABITS(AB), .DBITS(DB), .MAX_LOCK(ML)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .lock_i(lock), .addr_i(addr),
    .we_i(we), .be_i(be), .din_i(din), .gnt_o(gnt), .rvalid_o(rvalid),
    .dout_o(dout), .ram_addr_o(ram_addr), .ram_we_o(ram_we), .ram_be_o(ram_be),
    .ram_din_o(ram_din), .ram_dout_i(ram_dout)
  );

  function automatic logic [DB-1:0] preload(input int a);
    if (a == 'h3A5) return 32'hDEADBEEF;
    return 32'hC0DE_0000 ^ (32'(a) * 32'h0001_9E37);
  endfunction

  // Behavioural synchronous RAM attached to the arbiter's RAM port.
  logic [DB-1:0] env_mem [0:1023];
  initial for (int a = 0; a < 1024; a++) env_mem[a] <= preload(a);
  always @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < BB; b++) begin
        if (ram_be[b]) env_mem[ram_addr][b*8 +: 8] <= ram_din[b*8 +: 8];
      end
    end else begin
      ram_dout <= env_mem[ram_addr];
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [NP-1:0] gnt;
    logic [NP-1:0] rvalid;
    logic [AB-1:0] addr;
    logic          we;
    logic [BB-1:0] be;
    logic [DB-1:0] din;
  } cyc_t;
  typedef struct packed {
    logic [NP-1:0] port;
    logic [DB-1:0] data;
  } rd_t;

  cyc_t exp_q[$];
  rd_t  rd_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: mid-cycle, compare every presented output against the queues.
  initial begin
    cyc_t e;
    rd_t  r;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("gnt", 64'(gnt), 64'(e.gnt));
        chk("rvalid", 64'(rvalid), 64'(e.rvalid));
        chk("ram_we", 64'(ram_we), 64'(e.we));
        chk("ram_be", 64'(ram_be), 64'(e.be));
        chk("ram_addr", 64'(ram_addr), 64'(e.addr));
        chk("ram_din", 64'(ram_din), 64'(e.din));
      end
      if (rvalid != '0) begin
        if (rd_q.size() == 0) begin
          chk("rd_unexpected", 64'(rvalid), 64'(0));
        end else begin
          r = rd_q.pop_front();
          chk("rd_port", 64'(rvalid), 64'(r.port));
          chk("rd_data", 64'(dout), 64'(r.data));
        end
      end
    end
  end

  // ---------------- reference model ----------------
  bit            p_req [NP];
  bit            p_we  [NP];
  bit            p_lock[NP];
  logic [AB-1:0] p_addr[NP];
  logic [BB-1:0] p_be  [NP];
  logic [DB-1:0] p_din [NP];

  logic [DB-1:0] ref_mem [0:1023];
  int            m_last, m_owner, m_cnt, m_rd_port, last_g;
  logic [DB-1:0] m_rd_data;
  logic [AB-1:0] m_hold_addr;
  logic [DB-1:0] m_hold_din;

  task automatic set_req(input int n, input bit w, input int a, input int b,
                         input logic [DB-1:0] d);
    p_req[n]  = 1'b1;
    p_we[n]   = w;
    p_addr[n] = AB'(a);
    p_be[n]   = BB'(b);
    p_din[n]  = d;
  endtask

  // Driver + model: apply one cycle of stimulus just after the edge and
  // predict what the DUT must show during that cycle.
  task automatic step(input bit do_rst);
    cyc_t e;
    int   g;
    @(posedge clk);
    #1;
    rst = do_rst;
    for (int n = 0; n < NP; n++) begin
      req[n]             = p_req[n];
      lock[n]            = p_lock[n];
      we[n]              = p_we[n];
      addr[n*AB +: AB]   = p_addr[n];
      be[n*BB +: BB]     = p_be[n];
      din[n*DB +: DB]    = p_din[n];
    end
    e = '0;
    if (!do_rst && m_rd_port >= 0) begin
      e.rvalid = NP'(1) << m_rd_port;
      rd_q.push_back('{port: NP'(1) << m_rd_port, data: m_rd_data});
    end
    m_rd_port = -1;
    g = -1;
    if (do_rst) begin
      m_last = NP - 1; m_owner = -1; m_cnt = 0;
      m_hold_addr = '0; m_hold_din = '0;
    end else if (m_owner >= 0 && p_req[m_owner]) begin
      g = m_owner;
    end else begin
      for (int k = 1; k <= NP; k++) begin
        if (g < 0 && p_req[(m_last + k) % NP]) g = (m_last + k) % NP;
      end
    end
    if (g >= 0) begin
      e.gnt = NP'(1) << g;
      e.addr = p_addr[g]; e.we = p_we[g]; e.be = p_be[g]; e.din = p_din[g];
      m_hold_addr = p_addr[g];
      m_hold_din  = p_din[g];
      if (p_we[g]) begin
        for (int b = 0; b < BB; b++) begin
          if (p_be[g][b]) ref_mem[p_addr[g]][b*8 +: 8] = p_din[g][b*8 +: 8];
        end
      end else begin
        m_rd_port = g;
        m_rd_data = ref_mem[p_addr[g]];
      end
      if (p_lock[g]) begin
        if (g == m_owner) m_cnt++;
        else begin m_owner = g; m_cnt = 1; end
        if (m_cnt >= ML) begin m_owner = -1; m_cnt = 0; end
      end else begin
        m_owner = -1; m_cnt = 0;
      end
      m_last = g;
      p_req[g] = 1'b0;
    end else begin
      e.addr = m_hold_addr;
      e.din  = m_hold_din;
      m_owner = -1; m_cnt = 0;
    end
    exp_q.push_back(e);
    last_g = g;
  endtask

  task automatic clear_all();
    for (int n = 0; n < NP; n++) begin
      p_req[n] = 0; p_we[n] = 0; p_lock[n] = 0;
      p_addr[n] = '0; p_be[n] = '0; p_din[n] = '0;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int a = 0; a < 1024; a++) ref_mem[a] = preload(a);
    m_last = NP - 1; m_owner = -1; m_cnt = 0; m_rd_port = -1; last_g = -1;
    m_rd_data = '0; m_hold_addr = '0; m_hold_din = '0;
    clear_all();
    rst = 1'b1; req = '0; lock = '0; we = '0; addr = '0; be = '0; din = '0;

    // Reset state.
    step(1); step(1);

    // All four read continuously: rotation 0,1,2,3,0.
    for (int n = 0; n < NP; n++) set_req(n, 0, 'h10 + n, 'hF, '0);
    for (int i = 0; i < 5; i++) begin
      step(0);
      if (last_g >= 0) set_req(last_g, 0, 'h10 + last_g, 'hF, '0);
    end
    clear_all();
    step(0);

    // Port 2 reads the preloaded word, then idle cycles hold the address.
    set_req(2, 0, 'h3A5, 'hF, '0);
    step(0); step(0); step(0);

    // Partial write by port 1, read back by port 3 on the next cycle.
    set_req(1, 1, 5, 'h3, 32'h12345678);
    step(0);
    set_req(3, 0, 5, 'hF, '0);
    step(0); step(0);

    // Port 0 locks with everyone requesting: 8 grants to 0, then 1,2,3,0.
    for (int n = 0; n < NP; n++) set_req(n, 0, 'h20 + n, 'hF, '0);
    p_lock[0] = 1;
    for (int i = 0; i < 12; i++) begin
      step(0);
      if (last_g >= 0) set_req(last_g, 0, 'h20 + last_g, 'hF, '0);
    end
    clear_all();
    step(0);

    // Reset right after a granted read; afterwards lowest requester wins.
    set_req(2, 0, 'h3A5, 'hF, '0);
    step(0);
    set_req(1, 0, 7, 'hF, '0);
    set_req(3, 0, 8, 'hF, '0);
    step(1); step(1);
    step(0); step(0); step(0);

    // Randomised traffic with sticky locks and occasional resets.
    for (int i = 0; i < 600; i++) begin
      for (int n = 0; n < NP; n++) begin
        if ($urandom_range(0, 9) == 0) p_lock[n] = !p_lock[n];
        if (!p_req[n] && (p_lock[n] ? ($urandom_range(0, 9) < 9) : ($urandom_range(0, 1) == 1)))
          set_req(n, $urandom_range(0, 1) == 1, $urandom_range(0, 31),
                  $urandom_range(0, 15), $urandom());
      end
      step($urandom_range(0, 79) == 0);
    end

    // Drain.
    clear_all();
    step(0); step(0); step(0);
    @(negedge clk);
    #1;
    chk("exp_q_drained", 64'(exp_q.size()), 64'(0));
    chk("rd_q_drained", 64'(rd_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
